// File: rtl/pipe_seq_pkg.sv
// Shared encodings for the pipeline sequencing controller and the ID stage.
// Pure definitions: no latency, no flow control.
package pipe_seq_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ISSUE = 2'd2,
      ST_REDIR = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'd0,
      PC_BR   = 2'd1,
      PC_TRAP = 2'd2,
      PC_XEPC = 2'd3
   } pc_sel_e;

   typedef enum logic [1:0] {
      CSR_NONE = 2'd0,
      CSR_RW   = 2'd1,
      CSR_RS   = 2'd2
   } csr_op_e;

   typedef enum logic [1:0] {
      RET_NONE = 2'd0,
      RET_MRET = 2'd1,
      RET_SRET = 2'd2
   } priv_ret_e;

   localparam int DRAIN_CNT_W = 3;

   // CSR accesses and xRETs both need every older instruction retired first.
   function automatic logic needs_serialise(input logic [1:0] csr_op, input logic [1:0] priv_ret);
      return (csr_op != CSR_NONE) || (priv_ret != RET_NONE);
   endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Hazard/redirect bundle between the pipeline datapath (master) and the sequencer (slave).
// Wires only: no latency, no flow control.
interface pipe_seq_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_mem_write;
   logic [1:0] id_csr_op;
   logic [1:0] id_priv_ret;
   logic       ex_mem_read;
   logic [4:0] ex_rd;
   logic       ex_br_taken;
   logic       mem_busy;
   logic       trap_req;
   logic       ctrl_stall;
   logic       pc_stall;
   logic       if_id_stall;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       ex_mem_stall;
   logic [1:0] pc_sel;
   logic [1:0] seq_state;

   modport master (
      output id_rs1, id_rs2, id_mem_write, id_csr_op, id_priv_ret,
             ex_mem_read, ex_rd, ex_br_taken, mem_busy, trap_req,
      input  ctrl_stall, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
             ex_mem_stall, pc_sel, seq_state
   );

   modport slave (
      input  id_rs1, id_rs2, id_mem_write, id_csr_op, id_priv_ret,
             ex_mem_read, ex_rd, ex_br_taken, mem_busy, trap_req,
      output ctrl_stall, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
             ex_mem_stall, pc_sel, seq_state
   );
endinterface

// File: rtl/pipe_seq_ctrl_hazard_cmp.sv
// Load-use comparator between the EX load and the ID sources; purely combinational.
// x0 never hazards, and a store's rs2 is covered by store-data forwarding.
module hazard_cmp (
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_ex_rd,
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic       i_id_mem_write,
   output logic       o_hit
);
   logic w_rd_live;
   logic w_rs1_match;
   logic w_rs2_match;

   assign w_rd_live   = i_ex_mem_read && (i_ex_rd != 5'd0);
   assign w_rs1_match = (i_ex_rd == i_id_rs1);
   assign w_rs2_match = (i_ex_rd == i_id_rs2) && !i_id_mem_write;
   assign o_hit       = w_rd_live && (w_rs1_match || w_rs2_match);
endmodule

// File: rtl/pipe_seq_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage core: load-use bubbles, CSR/xRET drains, PC redirects.
// Outputs are combinational from state and inputs; mem_busy freezes the sequencer and holds the pipe.
module pipe_seq_ctrl
   import pipe_seq_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
) (
   input logic           clk,
   input logic           rstn,
   pipe_seq_ctrl_if.slave bus
);
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   seq_state_e             r_state;
   logic [DRAIN_CNT_W-1:0] r_drain_cnt;
   logic [1:0]             r_ret_kind;

   seq_state_e             w_state_nxt;
   logic [DRAIN_CNT_W-1:0] w_cnt_nxt;
   logic [1:0]             w_ret_nxt;
   logic                   w_hold;
   logic                   w_bubble;
   logic                   w_flush;
   logic                   w_mem_hold;
   pc_sel_e                w_pc_sel;
   logic                   w_load_use;

   hazard_cmp u_hazard_cmp (
      .i_ex_mem_read  (bus.ex_mem_read),
      .i_ex_rd        (bus.ex_rd),
      .i_id_rs1       (bus.id_rs1),
      .i_id_rs2       (bus.id_rs2),
      .i_id_mem_write (bus.id_mem_write),
      .o_hit          (w_load_use)
   );

   // r_drain_cnt counts the DRAIN cycles still ahead, including the current one.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_drain_cnt;
      w_ret_nxt   = r_ret_kind;
      w_hold      = 1'b0;
      w_bubble    = 1'b0;
      w_flush     = 1'b0;
      w_mem_hold  = 1'b0;
      w_pc_sel    = PC_SEQ;
      if (bus.mem_busy) begin
         w_hold     = 1'b1;
         w_mem_hold = 1'b1;
      end else if (bus.trap_req) begin
         w_flush     = 1'b1;
         w_pc_sel    = PC_TRAP;
         w_state_nxt = ST_RUN;
      end else if (bus.ex_br_taken) begin
         w_flush     = 1'b1;
         w_pc_sel    = PC_BR;
         w_state_nxt = ST_RUN;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (needs_serialise(bus.id_csr_op, bus.id_priv_ret)) begin
                  w_hold      = 1'b1;
                  w_bubble    = 1'b1;
                  w_ret_nxt   = bus.id_priv_ret;
                  w_cnt_nxt   = DRAIN_INIT;
                  w_state_nxt = (DRAIN_CYCLES > 1) ? ST_DRAIN : ST_ISSUE;
               end else if (w_load_use) begin
                  w_hold   = 1'b1;
                  w_bubble = 1'b1;
               end
            end
            ST_DRAIN: begin
               w_hold   = 1'b1;
               w_bubble = 1'b1;
               if (r_drain_cnt <= DRAIN_CNT_W'(1)) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_cnt_nxt = r_drain_cnt - DRAIN_CNT_W'(1);
               end
            end
            ST_ISSUE: begin
               w_state_nxt = (r_ret_kind != RET_NONE) ? ST_REDIR : ST_RUN;
            end
            ST_REDIR: begin
               w_flush     = 1'b1;
               w_pc_sel    = PC_XEPC;
               w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= '0;
         r_ret_kind  <= RET_NONE;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_cnt_nxt;
         r_ret_kind  <= w_ret_nxt;
      end
   end

   // Gate with rstn so every output reads 0 the moment reset lands, whatever the inputs do.
   assign bus.ctrl_stall   = rstn & w_bubble;
   assign bus.pc_stall     = rstn & w_hold;
   assign bus.if_id_stall  = rstn & w_hold;
   assign bus.if_id_flush  = rstn & w_flush;
   assign bus.id_ex_flush  = rstn & w_flush;
   assign bus.ex_mem_stall = rstn & w_mem_hold;
   assign bus.pc_sel       = rstn ? w_pc_sel : PC_SEQ;
   assign bus.seq_state    = rstn ? r_state : ST_RUN;
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: fixed vector table, hand sequences for drain corners, then random vs a model.
module tb_pipe_seq_ctrl;
   import pipe_seq_pkg::*;

   localparam int DC = 3;
   localparam logic [5:0] F_NONE  = 6'b000000;
   localparam logic [5:0] F_STALL = 6'b111000;
   localparam logic [5:0] F_FLUSH = 6'b000110;
   localparam logic [5:0] F_BUSY  = 6'b011001;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   pipe_seq_ctrl_if bus();
   pipe_seq_ctrl #(.DRAIN_CYCLES(DC)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       mw;
      logic [1:0] csr;
      logic [1:0] pr;
      logic       mr;
      logic [4:0] rd;
      logic       br;
      logic       busy;
      logic       trap;
      logic [9:0] xp;
   } vec_t;

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];

   // Reference model: pending bubbles, then an issue slot, then an optional redirect.
   int m_bub;
   bit m_iss, m_red, m_retk;

   function automatic logic [9:0] ex(logic [5:0] f, logic [1:0] pcs, logic [1:0] st);
      return {f, pcs, st};
   endfunction

   function automatic vec_t mkv(logic [4:0] rs1, logic [4:0] rs2, logic mw, logic [1:0] csr,
                                logic [1:0] pr, logic mr, logic [4:0] rd, logic br,
                                logic busy, logic trap, logic [9:0] xp);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.mw = mw; v.csr = csr; v.pr = pr;
      v.mr = mr; v.rd = rd; v.br = br; v.busy = busy; v.trap = trap; v.xp = xp;
      return v;
   endfunction

   function automatic vec_t mkf(logic [1:0] csr, logic [1:0] pr, logic br, logic busy,
                                logic trap, logic [9:0] xp);
      return mkv(5'd0, 5'd0, 1'b0, csr, pr, 1'b0, 5'd0, br, busy, trap, xp);
   endfunction

   task automatic drive(input vec_t v);
      bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2; bus.id_mem_write = v.mw;
      bus.id_csr_op = v.csr; bus.id_priv_ret = v.pr; bus.ex_mem_read = v.mr;
      bus.ex_rd = v.rd; bus.ex_br_taken = v.br; bus.mem_busy = v.busy; bus.trap_req = v.trap;
   endtask

   function automatic logic [9:0] observe();
      return {bus.ctrl_stall, bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_flush,
              bus.ex_mem_stall, bus.pc_sel, bus.seq_state};
   endfunction

   task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b (ctrl,pc,ifs,iff,ief,ems,pcsel,state)", nm, got, want);
      end
   endtask

   // Called at posedge+1: apply, sample at the falling edge, advance to the next posedge+1.
   task automatic cycle_chk(input string nm, input vec_t v);
      drive(v);
      #4;
      chk(nm, observe(), v.xp);
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(inout vec_t v);
      logic [1:0] st;
      logic [5:0] f;
      logic [1:0] pcs;
      bit lu;
      st  = (m_bub > 0) ? 2'd1 : m_iss ? 2'd2 : m_red ? 2'd3 : 2'd0;
      f   = F_NONE;
      pcs = 2'd0;
      lu  = v.mr && (v.rd != 0) && ((v.rd == v.rs1) || ((v.rd == v.rs2) && !v.mw));
      if (v.busy) begin
         f = F_BUSY;
      end else if (v.trap || v.br) begin
         f = F_FLUSH; pcs = v.trap ? 2'd2 : 2'd1;
         m_bub = 0; m_iss = 0; m_red = 0;
      end else if (m_bub > 0) begin
         f = F_STALL; m_bub--;
         if (m_bub == 0) m_iss = 1;
      end else if (m_iss) begin
         m_iss = 0; m_red = m_retk;
      end else if (m_red) begin
         f = F_FLUSH; pcs = 2'd3; m_red = 0;
      end else if (v.csr != 0 || v.pr != 0) begin
         f = F_STALL; m_retk = (v.pr != 0);
         m_bub = DC - 1;
         if (m_bub == 0) m_iss = 1;
      end else if (lu) begin
         f = F_STALL;
      end
      v.xp = {f, pcs, st};
   endtask

   initial begin
      vec_t z, v;
      z = mkf(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(F_NONE, 2'd0, 2'd0));

      rstn = 1'b0;
      drive(z);
      #3;
      chk("reset_state", observe(), ex(F_NONE, 2'd0, 2'd0));
      @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;

      tbl.push_back(z);
      tbl.push_back(mkv(5, 1, 0, 0, 0, 1, 5, 0, 0, 0, ex(F_STALL, 0, 0)));
      tbl.push_back(mkv(6, 5, 0, 0, 0, 0, 0, 0, 0, 0, ex(F_NONE, 0, 0)));
      tbl.push_back(mkv(2, 5, 1, 0, 0, 1, 5, 0, 0, 0, ex(F_NONE, 0, 0)));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ex(F_NONE, 0, 0)));
      tbl.push_back(mkv(3, 7, 0, 0, 0, 1, 7, 0, 0, 0, ex(F_STALL, 0, 0)));
      tbl.push_back(mkv(7, 7, 1, 0, 0, 1, 7, 0, 0, 0, ex(F_STALL, 0, 0)));
      tbl.push_back(mkf(1, 0, 0, 0, 0, ex(F_STALL, 0, 0)));
      tbl.push_back(mkf(1, 0, 0, 0, 0, ex(F_STALL, 0, 1)));
      tbl.push_back(mkf(1, 0, 0, 0, 0, ex(F_STALL, 0, 1)));
      tbl.push_back(mkf(1, 0, 0, 0, 0, ex(F_NONE, 0, 2)));
      tbl.push_back(mkf(2, 0, 0, 0, 0, ex(F_STALL, 0, 0)));
      tbl.push_back(mkf(2, 0, 0, 0, 0, ex(F_STALL, 0, 1)));
      tbl.push_back(mkf(2, 0, 0, 0, 0, ex(F_STALL, 0, 1)));
      tbl.push_back(mkv(5, 0, 0, 2, 0, 1, 5, 0, 0, 0, ex(F_NONE, 0, 2)));
      tbl.push_back(mkf(0, 1, 0, 0, 0, ex(F_STALL, 0, 0)));
      tbl.push_back(mkf(0, 1, 0, 0, 0, ex(F_STALL, 0, 1)));
      tbl.push_back(mkf(0, 1, 0, 0, 0, ex(F_STALL, 0, 1)));
      tbl.push_back(mkf(0, 1, 0, 0, 0, ex(F_NONE, 0, 2)));
      tbl.push_back(mkf(0, 0, 0, 0, 0, ex(F_FLUSH, 3, 3)));
      tbl.push_back(z);
      tbl.push_back(mkv(5, 0, 0, 0, 0, 1, 5, 1, 0, 0, ex(F_FLUSH, 1, 0)));
      tbl.push_back(mkf(0, 0, 0, 0, 1, ex(F_FLUSH, 2, 0)));
      tbl.push_back(z);
      for (int i = 0; i < tbl.size(); i++)
         cycle_chk($sformatf("vec%0d", i), tbl[i]);

      // Trap in the second DRAIN cycle abandons the pending mret redirect.
      cycle_chk("trap_run",    mkf(0, 1, 0, 0, 0, ex(F_STALL, 0, 0)));
      cycle_chk("trap_drain1", mkf(0, 1, 0, 0, 0, ex(F_STALL, 0, 1)));
      cycle_chk("trap_hit",    mkf(0, 1, 0, 0, 1, ex(F_FLUSH, 2, 1)));
      cycle_chk("trap_after0", z);
      cycle_chk("trap_after1", z);

      // mem_busy freezes an sret drain at its last DRAIN cycle; trap inside is ignored.
      cycle_chk("busy_run",    mkf(0, 2, 0, 0, 0, ex(F_STALL, 0, 0)));
      cycle_chk("busy_drain",  mkf(0, 2, 0, 0, 0, ex(F_STALL, 0, 1)));
      for (int i = 0; i < 4; i++)
         cycle_chk($sformatf("busy_hold%0d", i),
                   mkf(0, 2, 0, 1, (i == 1), ex(F_BUSY, 0, 1)));
      cycle_chk("busy_resume", mkf(0, 2, 0, 0, 0, ex(F_STALL, 0, 1)));
      cycle_chk("busy_issue",  mkf(0, 2, 0, 0, 0, ex(F_NONE, 0, 2)));
      cycle_chk("busy_redir",  mkf(0, 0, 0, 0, 0, ex(F_FLUSH, 3, 3)));
      cycle_chk("busy_idle",   z);

      // Asynchronous reset in the middle of a drain.
      cycle_chk("arst_run",    mkf(1, 0, 0, 0, 0, ex(F_STALL, 0, 0)));
      drive(mkf(1, 0, 0, 0, 0, ex(F_STALL, 0, 1)));
      #2;
      chk("arst_pre", observe(), ex(F_STALL, 0, 1));
      rstn = 1'b0;
      #1;
      chk("arst_now", observe(), ex(F_NONE, 0, 0));
      @(posedge clk);
      #1;
      chk("arst_held", observe(), ex(F_NONE, 0, 0));
      drive(z);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      cycle_chk("arst_idle", z);
      cycle_chk("arst_csr",  mkf(1, 0, 0, 0, 0, ex(F_STALL, 0, 0)));
      cycle_chk("arst_csr1", mkf(1, 0, 0, 0, 0, ex(F_STALL, 0, 1)));

      // Randomised run against the model, starting from a fresh reset.
      drive(z);
      rstn = 1'b0;
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      m_bub = 0; m_iss = 0; m_red = 0; m_retk = 0;
      for (int i = 0; i < 1500; i++) begin
         v.rs1  = 5'($urandom_range(0, 3));
         v.rs2  = 5'($urandom_range(0, 3));
         v.rd   = 5'($urandom_range(0, 3));
         v.mw   = ($urandom_range(0, 3) == 0);
         v.mr   = ($urandom_range(0, 1) == 0);
         v.csr  = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
         v.pr   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
         v.br   = ($urandom_range(0, 11) == 0);
         v.busy = ($urandom_range(0, 6) == 0);
         v.trap = ($urandom_range(0, 19) == 0);
         model_step(v);
         cycle_chk($sformatf("rand%0d", i), v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
